// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, row synchroniser, per-scan key census,
// debounce FSM and a four-deep history of accepted keys for the seven-segment display.
module keypad_scanner #(
  parameter int unsigned COL_CYCLES     = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3
);

  localparam int unsigned TimerW = $clog2(COL_CYCLES);
  localparam int unsigned DcntW  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(COL_CYCLES - 1);
  localparam logic [DcntW-1:0]  DcntDone  = DcntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

  state_e            state_q, state_d;
  logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [3:0]        acc_code_q, acc_code_d;
  logic [DcntW-1:0]  dcnt_q, dcnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_down_q, key_down_d;
  logic [3:0]        digit0_q, digit0_d, digit1_q, digit1_d;
  logic [3:0]        digit2_q, digit2_d, digit3_q, digit3_d;

  logic [3:0]       pressed;
  logic [1:0]       first_row;
  logic [2:0]       col_cnt, scan_sum;
  logic [1:0]       scan_cnt;
  logic [3:0]       scan_code;
  logic             sample, scan_end, accept;
  logic [DcntW-1:0] dcnt_inc;

  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    unique case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  always_comb begin
    sync1_d     = row;
    sync2_d     = sync1_q;
    timer_d     = timer_q + 1'b1;
    col_idx_d   = col_idx_q;
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    digit0_d    = digit0_q;
    digit1_d    = digit1_q;
    digit2_d    = digit2_q;
    digit3_d    = digit3_q;
    accept      = 1'b0;

    pressed   = ~sync2_q;
    first_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (pressed[r]) first_row = 2'(r);
    end
    col_cnt   = 3'($countones(pressed));
    scan_sum  = {1'b0, acc_cnt_q} + col_cnt;
    scan_cnt  = (scan_sum >= 3'd2) ? 2'd2 : scan_sum[1:0];
    // Earlier columns win, so a code already captured is kept.
    scan_code = (acc_cnt_q != 2'd0) ? acc_code_q : key_of(first_row, col_idx_q);
    sample    = (timer_q == TimerLast);
    scan_end  = sample && (col_idx_q == 2'd3);
    dcnt_inc  = (dcnt_q >= DcntDone) ? dcnt_q : dcnt_q + 1'b1;

    if (sample) begin
      timer_d   = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (scan_end) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'h0;
      end else begin
        acc_cnt_d  = scan_cnt;
        acc_code_d = scan_code;
      end
    end

    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (scan_cnt == 2'd1) begin
            cand_d = scan_code;
            dcnt_d = DcntW'(1);
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = StPressed;
              accept  = 1'b1;
            end else begin
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (scan_cnt == 2'd1 && scan_code == cand_q) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DcntDone) begin
              state_d = StPressed;
              accept  = 1'b1;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StPressed: begin
          if (scan_cnt == 2'd0) begin
            dcnt_d = DcntW'(1);
            if (DEBOUNCE_SCANS <= 1) begin
              state_d    = StIdle;
              key_down_d = 1'b0;
            end else begin
              state_d = StRelease;
            end
          end
        end
        StRelease: begin
          if (scan_cnt == 2'd0) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DcntDone) begin
              state_d    = StIdle;
              key_down_d = 1'b0;
            end
          end else begin
            state_d = StPressed;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = scan_code;
      key_down_d  = 1'b1;
      digit3_d    = digit2_q;
      digit2_d    = digit1_q;
      digit1_d    = digit0_q;
      digit0_d    = scan_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      timer_q     <= '0;
      col_idx_q   <= 2'd0;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'h0;
      dcnt_q      <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      digit0_q    <= 4'h0;
      digit1_q    <= 4'h0;
      digit2_q    <= 4'h0;
      digit3_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      timer_q     <= timer_d;
      col_idx_q   <= col_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      dcnt_q      <= dcnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      digit0_q    <= digit0_d;
      digit1_q    <= digit1_d;
      digit2_q    <= digit2_d;
      digit3_q    <= digit3_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign digit0    = digit0_q;
  assign digit1    = digit1_q;
  assign digit2    = digit2_q;
  assign digit3    = digit3_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural 4x4 keypad drives the rows from the
// column strobes; each task scripts presses and checks pulses, codes and the digit history.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key_code, digit0, digit1, digit2, digit3;
  logic       key_valid, key_down;
  logic [3:0] prs [4];
  logic [3:0] hist [$];
  int         errors = 0;
  int         checks = 0;
  int         pulse_cnt = 0;

  keypad_scanner #(
    .COL_CYCLES    (8),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3)
  );

  always #5 clk = ~clk;

  // A row reads low when any pressed key in it sits on the currently driven column.
  assign row[0] = ~|(prs[0] & ~col);
  assign row[1] = ~|(prs[1] & ~col);
  assign row[2] = ~|(prs[2] & ~col);
  assign row[3] = ~|(prs[3] & ~col);

  always @(negedge clk) begin
    if (key_valid) begin
      pulse_cnt = pulse_cnt + 1;
      hist.push_back(key_code);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [1:0] r, input logic [1:0] c, input logic v);
    prs[r][c] = v;
  endtask

  task automatic test_reset();
    int p0, bad;
    for (int r = 0; r < 4; r++) prs[r] = 4'h0;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h want 0", key_code); end
    checks++; if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
      errors++; $display("FAIL reset_digits: got %h want 0000", {digit3, digit2, digit1, digit0});
    end
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_down: got %b want 0", key_down); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    rst_n = 1'b1;
    p0 = pulse_cnt;
    bad = 0;
    repeat (500) begin
      tick();
      if ($countones(~col) != 1) bad++;
    end
    checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt - p0); end
    checks++; if (bad != 0) begin errors++; $display("FAIL col_onehot: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_press5();
    int p0, n;
    p0 = pulse_cnt;
    n = 0;
    set_key(2'd1, 2'd1, 1'b1);
    while (key_valid !== 1'b1 && n < 132) begin tick(); n++; end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press5_latency: got no pulse in %0d cycles want <=132", n); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL press5_code: got %h want 5", key_code); end
    checks++; if (digit0 !== 4'h5) begin errors++; $display("FAIL press5_digit0: got %h want 5", digit0); end
    checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL press5_down: got %b want 1", key_down); end
    repeat (300 - n) tick();
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL press5_pulses: got %0d want 1", pulse_cnt - p0); end
    set_key(2'd1, 2'd1, 1'b0);
    repeat (32) tick();
    checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL release_early: got key_down %b want 1", key_down); end
    n = 0;
    while (key_down !== 1'b0 && n < 160) begin tick(); n++; end
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL release_down: got %b want 0", key_down); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    set_key(2'd2, 2'd0, 1'b1);
    repeat (40) tick();
    set_key(2'd2, 2'd0, 1'b0);
    repeat (200) tick();
    checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", pulse_cnt - p0); end
    checks++; if (digit0 !== 4'h5) begin errors++; $display("FAIL bounce_digit0: got %h want 5", digit0); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL bounce_code: got %h want 5", key_code); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL bounce_down: got %b want 0", key_down); end
  endtask

  task automatic test_sequence();
    int p0, hs;
    logic [15:0] got;
    p0 = pulse_cnt;
    for (int c = 0; c < 4; c++) begin
      set_key(2'd0, 2'(c), 1'b1);
      repeat (200) tick();
      set_key(2'd0, 2'(c), 1'b0);
      repeat (200) tick();
    end
    checks++; if (pulse_cnt - p0 != 4) begin errors++; $display("FAIL seq_pulses: got %0d want 4", pulse_cnt - p0); end
    hs = hist.size();
    got = (hs >= 4) ? {hist[hs-4], hist[hs-3], hist[hs-2], hist[hs-1]} : 16'hxxxx;
    checks++; if (got !== 16'h123A) begin errors++; $display("FAIL seq_codes: got %h want 123a", got); end
    checks++; if (digit3 !== 4'h1) begin errors++; $display("FAIL seq_digit3: got %h want 1", digit3); end
    checks++; if (digit2 !== 4'h2) begin errors++; $display("FAIL seq_digit2: got %h want 2", digit2); end
    checks++; if (digit1 !== 4'h3) begin errors++; $display("FAIL seq_digit1: got %h want 3", digit1); end
    checks++; if (digit0 !== 4'hA) begin errors++; $display("FAIL seq_digit0: got %h want a", digit0); end
  endtask

  task automatic test_multi();
    int p0;
    p0 = pulse_cnt;
    set_key(2'd0, 2'd0, 1'b1);
    set_key(2'd0, 2'd1, 1'b1);
    repeat (200) tick();
    set_key(2'd0, 2'd0, 1'b0);
    set_key(2'd0, 2'd1, 1'b0);
    repeat (200) tick();
    checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL multi_pulses: got %0d want 0", pulse_cnt - p0); end
    set_key(2'd2, 2'd2, 1'b1);
    repeat (200) tick();
    set_key(2'd0, 2'd2, 1'b1);
    repeat (200) tick();
    set_key(2'd2, 2'd2, 1'b0);
    set_key(2'd0, 2'd2, 1'b0);
    repeat (200) tick();
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL hold_add_pulses: got %0d want 1", pulse_cnt - p0); end
    checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL hold_add_code: got %h want 9", key_code); end
    checks++; if (digit0 !== 4'h9) begin errors++; $display("FAIL hold_add_digit0: got %h want 9", digit0); end
    checks++; if (digit1 !== 4'hA) begin errors++; $display("FAIL hold_add_digit1: got %h want a", digit1); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL hold_add_down: got %b want 0", key_down); end
  endtask

  task automatic test_reset_mid();
    int p0, n;
    n = 0;
    while (col !== 4'b0111 && n < 40) begin tick(); n++; end
    while (col !== 4'b1110 && n < 80) begin tick(); n++; end
    checks++; if (col !== 4'b1110) begin errors++; $display("FAIL align_col: got %b want 1110", col); end
    p0 = pulse_cnt;
    set_key(2'd3, 2'd2, 1'b1);
    repeat (70) tick();
    checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL pre_reset_pulses: got %0d want 0", pulse_cnt - p0); end
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (key_valid !== 1'b0 || key_down !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got valid=%b down=%b want 0 0", key_valid, key_down);
    end
    checks++; if (digit0 !== 4'h0) begin errors++; $display("FAIL mid_reset_digit0: got %h want 0", digit0); end
    rst_n = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 110) begin tick(); n++; end
    checks++; if (key_valid !== 1'b1 || n < 94 || n > 98) begin
      errors++; $display("FAIL e_latency: got pulse=%b at cycle %0d want pulse at 94..98", key_valid, n);
    end
    checks++; if (key_code !== 4'hE) begin errors++; $display("FAIL e_code: got %h want e", key_code); end
    checks++; if (digit0 !== 4'hE || digit1 !== 4'h0) begin
      errors++; $display("FAIL e_digits: got %h%h want 0e", digit1, digit0);
    end
    repeat (2) tick();
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL e_pulses: got %0d want 1", pulse_cnt - p0); end
    set_key(2'd3, 2'd2, 1'b0);
    repeat (200) tick();
  endtask

  initial begin
    test_reset();
    test_press5();
    test_bounce();
    test_sequence();
    test_multi();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
